// File: rtl/ram_bubble_sort_if.sv
// Start/done handshake plus the read and write ports of the RAM being sorted.
// The sorter connects through the slave modport; the handshake source and RAM sit on master.
interface ram_bubble_sort_if #(
   parameter int width_p = 8,
   parameter int depth_p = 8
);
   localparam int addr_w  = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam int swaps_w = (depth_p > 1) ? $clog2(depth_p * depth_p) : 1;

   logic                valid_i;
   logic                ready_o;
   logic                valid_o;
   logic                ready_i;
   logic [swaps_w-1:0]  swaps_o;
   logic                ram_wr_valid_o;
   logic [addr_w-1:0]   ram_wr_addr_o;
   logic [width_p-1:0]  ram_wr_data_o;
   logic [addr_w-1:0]   ram_rd_addr_o;
   logic [width_p-1:0]  ram_rd_data_i;

   modport slave (
      input  valid_i, ready_i, ram_rd_data_i,
      output ready_o, valid_o, swaps_o,
             ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o
   );

   modport master (
      output valid_i, ready_i, ram_rd_data_i,
      input  ready_o, valid_o, swaps_o,
             ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o
   );
endinterface

// File: rtl/ram_bubble_sort.sv
// In-place ascending bubble sort over an asynchronous-read RAM, with an early exit
// after a pass that makes no swaps. The swap count is reported on completion.
module ram_bubble_sort #(
   parameter int width_p = 8,
   parameter int depth_p = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   ram_bubble_sort_if.slave bus
);
   localparam int addr_w  = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam int swaps_w = (depth_p > 1) ? $clog2(depth_p * depth_p) : 1;
   localparam logic [addr_w-1:0] last_init = addr_w'(depth_p - 1);

   if (depth_p < 2) begin : g_depth_check
      $error("ram_bubble_sort: depth_p must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPARE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              r_state, w_state_next;
   logic [width_p-1:0]  r_a, w_a_next;
   logic [addr_w-1:0]   r_i, w_i_next;
   logic [addr_w-1:0]   r_last, w_last_next;
   logic                r_swapped, w_swapped_next;
   logic [swaps_w-1:0]  r_swaps, w_swaps_next;

   logic                w_ready;
   logic                w_valid;
   logic                w_wr_valid;
   logic [addr_w-1:0]   w_wr_addr;
   logic [width_p-1:0]  w_wr_data;
   logic [addr_w-1:0]   w_rd_addr;
   logic                w_advance;
   logic [addr_w-1:0]   w_i_plus1;

   assign w_i_plus1 = r_i + addr_w'(1);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_i       <= '0;
         r_last    <= last_init;
         r_swapped <= 1'b0;
         r_swaps   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_a       <= w_a_next;
         r_i       <= w_i_next;
         r_last    <= w_last_next;
         r_swapped <= w_swapped_next;
         r_swaps   <= w_swaps_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_a_next       = r_a;
      w_i_next       = r_i;
      w_last_next    = r_last;
      w_swapped_next = r_swapped;
      w_swaps_next   = r_swaps;
      w_ready        = 1'b0;
      w_valid        = 1'b0;
      w_wr_valid     = 1'b0;
      w_wr_addr      = '0;
      w_wr_data      = '0;
      w_rd_addr      = '0;
      w_advance      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.valid_i) begin
               w_i_next     = '0;
               w_last_next  = last_init;
               w_swaps_next = '0;
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_rd_addr      = r_i;
            w_a_next       = bus.ram_rd_data_i;
            w_swapped_next = 1'b0;
            w_state_next   = S_COMPARE;
         end
         S_COMPARE: begin
            // r_a is the element carried up from mem[i]; compare it with mem[i+1].
            w_rd_addr = w_i_plus1;
            if (r_a > bus.ram_rd_data_i) begin
               w_wr_valid     = 1'b1;
               w_wr_addr      = r_i;
               w_wr_data      = bus.ram_rd_data_i;
               w_swapped_next = 1'b1;
               w_swaps_next   = r_swaps + swaps_w'(1);
               w_state_next   = S_WRITE;
            end else begin
               w_a_next  = bus.ram_rd_data_i;
               w_advance = 1'b1;
            end
         end
         S_WRITE: begin
            w_wr_valid = 1'b1;
            w_wr_addr  = w_i_plus1;
            w_wr_data  = r_a;
            w_advance  = 1'b1;
         end
         S_DONE: begin
            w_valid = 1'b1;
            if (bus.ready_i) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // r_swapped already includes a swap made by the final compare, since WRITE follows it.
      if (w_advance) begin
         if (w_i_plus1 < r_last) begin
            w_i_next     = w_i_plus1;
            w_state_next = S_COMPARE;
         end else if (!r_swapped || (r_last == addr_w'(1))) begin
            w_state_next = S_DONE;
         end else begin
            w_last_next  = r_last - addr_w'(1);
            w_i_next     = '0;
            w_state_next = S_LOAD;
         end
      end
   end

   assign bus.ready_o        = w_ready;
   assign bus.valid_o        = w_valid;
   assign bus.swaps_o        = r_swaps;
   assign bus.ram_wr_valid_o = w_wr_valid;
   assign bus.ram_wr_addr_o  = w_wr_addr;
   assign bus.ram_wr_data_o  = w_wr_data;
   assign bus.ram_rd_addr_o  = w_rd_addr;
endmodule

// File: tb/tb_ram_bubble_sort.sv
// Bench for ram_bubble_sort: two instances (depth 8 and depth 4) over behavioural
// async-read RAMs, with a reference bubble sort feeding a result scoreboard.
module tb_ram_bubble_sort;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start;
   logic ack;
   logic sel4;
   logic ld_en;
   logic [7:0][7:0] ld_data;

   int checks = 0;
   int errors = 0;

   ram_bubble_sort_if #(.width_p(8), .depth_p(8)) if8 ();
   ram_bubble_sort_if #(.width_p(8), .depth_p(4)) if4 ();

   ram_bubble_sort #(.width_p(8), .depth_p(8)) dut8 (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (if8.slave)
   );

   ram_bubble_sort #(.width_p(8), .depth_p(4)) dut4 (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (if4.slave)
   );

   logic [7:0] mem8 [8];
   logic [7:0] mem4 [4];
   int wr_cnt8 = 0;
   int wr_cnt4 = 0;

   assign if8.valid_i       = start & ~sel4;
   assign if4.valid_i       = start & sel4;
   assign if8.ready_i       = ack;
   assign if4.ready_i       = ack;
   assign if8.ram_rd_data_i = mem8[if8.ram_rd_addr_o];
   assign if4.ram_rd_data_i = mem4[if4.ram_rd_addr_o];

   // Behavioural RAMs: asynchronous read, write on the clock edge.
   always @(posedge clk) begin
      if (ld_en && !sel4) begin
         for (int k = 0; k < 8; k++) mem8[k] <= ld_data[k];
      end else if (if8.ram_wr_valid_o) begin
         mem8[if8.ram_wr_addr_o] <= if8.ram_wr_data_o;
         wr_cnt8 <= wr_cnt8 + 1;
      end
   end

   always @(posedge clk) begin
      if (ld_en && sel4) begin
         for (int k = 0; k < 4; k++) mem4[k] <= ld_data[k];
      end else if (if4.ram_wr_valid_o) begin
         mem4[if4.ram_wr_addr_o] <= if4.ram_wr_data_o;
         wr_cnt4 <= wr_cnt4 + 1;
      end
   end

   logic            obs_valid;
   logic            obs_ready;
   int              obs_swaps;
   int              obs_writes;
   logic [7:0][7:0] obs_mem;

   always_comb begin
      obs_mem = '0;
      if (sel4) begin
         obs_valid  = if4.valid_o;
         obs_ready  = if4.ready_o;
         obs_swaps  = int'(if4.swaps_o);
         obs_writes = wr_cnt4;
         for (int k = 0; k < 4; k++) obs_mem[k] = mem4[k];
      end else begin
         obs_valid  = if8.valid_o;
         obs_ready  = if8.ready_o;
         obs_swaps  = int'(if8.swaps_o);
         obs_writes = wr_cnt8;
         for (int k = 0; k < 8; k++) obs_mem[k] = mem8[k];
      end
   end

   typedef struct {
      logic [7:0][7:0] data;
      int              swaps;
      int              lat;
   } exp_t;

   exp_t sb[$];

   // Reference: plain bubble sort with early exit, charging 1 per pass, compare and swap.
   function automatic exp_t model(input int n, input logic [7:0][7:0] din);
      exp_t e;
      logic [7:0] t;
      int last;
      int sw;
      e.data  = din;
      e.swaps = 0;
      e.lat   = 0;
      last    = n - 1;
      while (1) begin
         sw    = 0;
         e.lat = e.lat + 1;
         for (int j = 0; j < last; j++) begin
            e.lat = e.lat + 1;
            if (e.data[j] > e.data[j+1]) begin
               t           = e.data[j];
               e.data[j]   = e.data[j+1];
               e.data[j+1] = t;
               sw          = sw + 1;
               e.lat       = e.lat + 1;
            end
         end
         e.swaps = e.swaps + sw;
         if (sw == 0 || last == 1) break;
         last = last - 1;
      end
      return e;
   endfunction

   task automatic load_ram(input int n, input logic [7:0][7:0] v);
      @(negedge clk);
      sel4 = (n == 4);
      ld_data = v;
      for (int k = n; k < 8; k++) ld_data[k] = 8'd0;
      ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic run_sort(input int n, input int hold, input bit pulse, input string tag);
      exp_t e;
      int cnt;
      int wr0;
      e = model(n, ld_data);
      sb.push_back(e);
      wr0 = obs_writes;
      @(negedge clk);
      ack   = (hold == 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt = 0;
      while (!obs_valid && cnt < 2000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (pulse) start = (cnt == 3);
      end
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s done_timeout got valid_o=%0b want 1 within 2000 cycles", tag, obs_valid);
      end
      checks++;
      if (cnt !== e.lat) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", tag, cnt, e.lat);
      end
      checks++;
      if (obs_swaps !== e.swaps) begin
         errors++;
         $display("FAIL %s swaps got %0d want %0d", tag, obs_swaps, e.swaps);
      end
      checks++;
      if ((obs_writes - wr0) !== 2 * e.swaps) begin
         errors++;
         $display("FAIL %s writes got %0d want %0d", tag, obs_writes - wr0, 2 * e.swaps);
      end
      checks++;
      if (obs_mem !== e.data) begin
         errors++;
         $display("FAIL %s ram got %h want %h", tag, obs_mem, e.data);
      end
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_valid !== 1'b1 || obs_swaps !== e.swaps) begin
               errors++;
               $display("FAIL %s hold cycle %0d got valid_o=%0b swaps=%0d want 1 %0d",
                        tag, h, obs_valid, obs_swaps, e.swaps);
            end
         end
         ack = 1'b1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release got valid_o=%0b ready_o=%0b want 0 1", tag, obs_valid, obs_ready);
      end
      $display("%s: n=%0d swaps=%0d latency=%0d", tag, n, obs_swaps, cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (if8.ready_o !== 1'b1 || if8.valid_o !== 1'b0 || if8.swaps_o !== 6'd0) begin
         errors++;
         $display("FAIL reset_handshake got ready=%0b valid=%0b swaps=%0d want 1 0 0",
                  if8.ready_o, if8.valid_o, if8.swaps_o);
      end
      checks++;
      if (if8.ram_wr_valid_o !== 1'b0 || if8.ram_wr_addr_o !== 3'd0 ||
          if8.ram_wr_data_o !== 8'd0 || if8.ram_rd_addr_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_ram_port got wv=%0b wa=%0d wd=%0d ra=%0d want 0 0 0 0",
                  if8.ram_wr_valid_o, if8.ram_wr_addr_o, if8.ram_wr_data_o, if8.ram_rd_addr_o);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("reset: outputs checked");
   endtask

   task automatic test_reset_busy();
      logic [7:0][7:0] v;
      int wr0;
      for (int k = 0; k < 8; k++) v[k] = 8'(7 - k);
      load_ram(8, v);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (if8.ready_o !== 1'b1 || if8.valid_o !== 1'b0 ||
          if8.ram_wr_valid_o !== 1'b0 || if8.swaps_o !== 6'd0) begin
         errors++;
         $display("FAIL reset_busy got ready=%0b valid=%0b wv=%0b swaps=%0d want 1 0 0 0",
                  if8.ready_o, if8.valid_o, if8.ram_wr_valid_o, if8.swaps_o);
      end
      @(negedge clk);
      rst = 1'b0;
      wr0 = wr_cnt8;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt8 !== wr0 || if8.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy_quiet got writes=%0d ready=%0b want %0d 1",
                  wr_cnt8, if8.ready_o, wr0);
      end
      $display("reset_busy: writes after reset=%0d", wr_cnt8 - wr0);
   endtask

   task automatic test_sorted();
      logic [7:0][7:0] v;
      for (int k = 0; k < 8; k++) v[k] = 8'(k);
      load_ram(8, v);
      run_sort(8, 0, 1'b0, "sorted8");
   endtask

   task automatic test_reverse4();
      logic [7:0][7:0] v;
      v = '0;
      v[0] = 8'd3; v[1] = 8'd2; v[2] = 8'd1; v[3] = 8'd0;
      load_ram(4, v);
      run_sort(4, 0, 1'b0, "reverse4");
   endtask

   task automatic test_dups4();
      logic [7:0][7:0] v;
      v = '0;
      v[0] = 8'd5; v[1] = 8'd5; v[2] = 8'd1; v[3] = 8'd5;
      load_ram(4, v);
      run_sort(4, 0, 1'b0, "dups4");
   endtask

   task automatic test_hold();
      logic [7:0][7:0] v;
      int wr0;
      for (int k = 0; k < 8; k++) v[k] = 8'(200 - 10 * k);
      load_ram(8, v);
      run_sort(8, 10, 1'b1, "hold8");
      wr0 = wr_cnt8;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt8 !== wr0 || if8.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL no_second_sort got writes=%0d ready=%0b want %0d 1",
                  wr_cnt8, if8.ready_o, wr0);
      end
   endtask

   task automatic test_random();
      logic [7:0][7:0] v;
      for (int t = 0; t < 100; t++) begin
         for (int k = 0; k < 8; k++) v[k] = 8'($urandom_range(0, (t % 3 == 0) ? 3 : 255));
         load_ram(8, v);
         run_sort(8, 0, 1'b0, $sformatf("random%0d", t));
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      ack     = 1'b1;
      sel4    = 1'b0;
      ld_en   = 1'b0;
      ld_data = '0;
      test_reset();
      test_reset_busy();
      test_sorted();
      test_reverse4();
      test_dups4();
      test_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
